// File: rtl/mlp_result_sequencer.sv
// Serialises staggered per-channel MLP results into one ordered valid/ready stream
// with round framing, selectable scan direction and sticky overflow detection.
module mlp_result_sequencer #(
  parameter  int NUM_GROUPS        = 4,
  parameter  int RESULTS_PER_GROUP = 2,
  parameter  int DOUT_WIDTH        = 48,
  parameter  int SCAN_DESCENDING   = 1,
  localparam int NUM_CH            = NUM_GROUPS * RESULTS_PER_GROUP,
  localparam int IDX_W             = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                         i_clk,
  input  logic                         i_reset_n,
  input  logic [NUM_CH*DOUT_WIDTH-1:0] i_result,
  input  logic [NUM_CH-1:0]            i_result_valid,
  input  logic                         i_flush,
  output logic [DOUT_WIDTH-1:0]        o_dout,
  output logic                         o_valid,
  input  logic                         i_ready,
  output logic [IDX_W-1:0]             o_index,
  output logic                         o_last,
  output logic                         o_busy,
  output logic                         o_overflow,
  output logic [15:0]                  o_round_count
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);
  localparam logic [IDX_W-1:0] FIRST_CH = (SCAN_DESCENDING != 0) ? LAST_IDX : '0;
  localparam logic [IDX_W-1:0] FINAL_CH = (SCAN_DESCENDING != 0) ? '0 : LAST_IDX;

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t                  state, state_nxt;
  logic [NUM_CH-1:0]       pending, pending_nxt, load_mask;
  logic [DOUT_WIDTH-1:0]   hold [NUM_CH];
  logic [IDX_W-1:0]        ptr, ptr_adv;
  logic                    load, is_final, ovf_hit;

  always_comb begin
    load      = pending[ptr] & (~o_valid | i_ready);
    is_final  = (ptr == FINAL_CH);
    load_mask = '0;
    if (load) load_mask[ptr] = 1'b1;
    // A strobe on the channel being loaded this edge refills it without overflow.
    ovf_hit     = |(i_result_valid & pending & ~load_mask);
    pending_nxt = (pending & ~load_mask) | i_result_valid;

    if (is_final)                  ptr_adv = FIRST_CH;
    else if (SCAN_DESCENDING != 0) ptr_adv = ptr - 1'b1;
    else                           ptr_adv = ptr + 1'b1;

    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (load && is_final && (pending_nxt == '0)) state_nxt = ST_IDLE;
        else if (|pending)                           state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (load && is_final && (pending_nxt == '0)) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state         <= ST_IDLE;
      pending       <= '0;
      ptr           <= FIRST_CH;
      o_valid       <= 1'b0;
      o_dout        <= '0;
      o_index       <= '0;
      o_last        <= 1'b0;
      o_overflow    <= 1'b0;
      o_round_count <= '0;
      for (int unsigned c = 0; c < NUM_CH; c++) hold[c] <= '0;
    end else if (i_flush) begin
      state      <= ST_IDLE;
      pending    <= '0;
      ptr        <= FIRST_CH;
      o_valid    <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      state   <= state_nxt;
      pending <= pending_nxt;
      if (ovf_hit) o_overflow <= 1'b1;
      for (int unsigned c = 0; c < NUM_CH; c++)
        if (i_result_valid[c]) hold[c] <= i_result[c*DOUT_WIDTH +: DOUT_WIDTH];
      if (load) begin
        o_dout  <= hold[ptr];
        o_index <= ptr;
        o_last  <= is_final;
        o_valid <= 1'b1;
        ptr     <= ptr_adv;
        if (is_final) o_round_count <= o_round_count + 16'd1;
      end else if (i_ready) begin
        o_valid <= 1'b0;
      end
    end
  end

  assign o_busy = (state == ST_RUN);

endmodule

// File: doc/mlp_result_sequencer.md
Name: mlp_result_sequencer

Overview:
- Parametrised successor to the fixed result chain at the output of the split-MLP shared-BRAM stack.
- Captures staggered parallel results from NUM_GROUPS groups, each with RESULTS_PER_GROUP outputs, in per-channel holding registers.
- Emits them as one ordered stream on a valid/ready handshake, with backpressure, round framing (last/index), selectable scan order and sticky overflow detection.
- Sits between split_mlp_shared_bram_stack result outputs and the downstream consumer (NoC/FIFO).

Parameters:
NUM_GROUPS, 4, MLP groups in the stack (1..32)
RESULTS_PER_GROUP, 2, result outputs per group (1 or 2)
DOUT_WIDTH, 48, result width (48, 24 or 16)
SCAN_DESCENDING, 1, 0 = channel 0 first; 1 = highest channel first (matches bottom-up stagger)
NUM_CH, NUM_GROUPS*RESULTS_PER_GROUP, derived, not overridable
IDX_W, max(1,$clog2(NUM_CH)), derived

Ports:
i_clk  in  1  shared clock
i_reset_n  in  1  asynchronous active-low reset
i_result  in  NUM_CH*DOUT_WIDTH  packed channel results, channel c = group c/RESULTS_PER_GROUP, sub-result c%RESULTS_PER_GROUP
i_result_valid  in  NUM_CH  per-channel one-cycle capture strobe
i_flush  in  1  synchronous: drop all pending data, restart round
o_dout  out  DOUT_WIDTH  output data
o_valid  out  1  output data valid
i_ready  in  1  consumer accepts when o_valid & i_ready
o_index  out  IDX_W  channel number of o_dout
o_last  out  1  o_dout is final channel of a round
o_busy  out  1  state RUN
o_overflow  out  1  sticky: result arrived on still-pending channel
o_round_count  out  16  completed rounds, wraps at 16'hFFFF -> 0

Behaviour:
- Reset: all pending bits 0, ptr = first channel (NUM_CH-1 if SCAN_DESCENDING else 0), state IDLE. Outputs: o_valid 0, o_dout 0, o_index 0, o_last 0, o_busy 0, o_overflow 0, o_round_count 0.
- Capture: at a clock edge with i_result_valid[c]=1, hold[c] <= i_result slice c and pending[c] <= 1.
- Output register loads when load = pending[ptr] & (!o_valid | i_ready). On load:
  - o_dout <= hold[ptr], o_index <= ptr, o_last <= (ptr == final channel), o_valid <= 1, pending[ptr] cleared.
  - ptr advances ±1 and wraps to the first channel after the final channel.
- Without load, o_valid <= 0 when i_ready=1; otherwise o_valid, o_dout, o_index and o_last stay stable.
- Latency: a strobe on channel ptr with the output empty gives o_valid two edges later. Full throughput is one result per cycle when all channels are pending and i_ready=1.
- Ordering is strict: ptr waits on its own channel even if other channels are pending.
- Simultaneous load and new strobe on channel ptr: old data goes to the output, new data is captured, and pending stays 1. No overflow.
- Overflow: a strobe on channel c with pending[c]=1 and no load of c that cycle.
  - Sets o_overflow, which stays set until reset or i_flush.
  - hold[c] is overwritten (newest data wins).
- FSM:
  - IDLE -> RUN on any pending bit.
  - RUN -> IDLE when a load with o_last=1 occurs and no pending bits remain after that edge.
  - o_round_count increments on every load of the final channel, in either state.
- i_flush (edge where high):
  - Clears pending, o_valid and o_overflow; ptr returns to the first channel; state goes to IDLE; o_round_count is unchanged.
  - Overrides same-cycle capture and load; strobes in that cycle are dropped.
- Asynchronous reset mid-stream: everything returns to the reset values immediately. No partial output remains visible.
- NUM_CH=1: ptr is constant, o_last is always 1 on valid, o_index is 0.

Test Plan:
- NUM_GROUPS=4, RPG=2, descending, i_ready=1; strobe channels 7..0 one per cycle, data = 0x100+c -> o_dout 0x107..0x100 on consecutive cycles, o_index 7..0, o_last only with 0x100, o_round_count=1, o_busy falls after the final beat.
- Same config, all 8 strobed in one cycle, i_ready toggling 1010… -> 8 beats in order 7..0. o_dout, o_index and o_last stay stable while i_ready=0. No overflow.
- Strobe only channel 3 (ascending mode) -> o_valid stays 0 until channels 0,1,2 arrive. Then 4 beats in order 0,1,2,3 on consecutive cycles.
- Strobe channel 5 twice, 3 cycles apart, while ptr waits on channel 6 -> o_overflow=1 stays set. The later value appears at index 5. The flush that follows clears o_overflow.
- Mid-round i_flush after 3 of 8 beats -> o_valid 0 next edge, o_busy 0, o_round_count unchanged. The next full round starts at the first channel.
- Assert i_reset_n low asynchronously while o_valid=1 and i_ready=0 -> all outputs 0 immediately. Release and run a full round -> o_round_count=1.
